// File: rtl/mem_stream_reader.sv
// Burst reader: issues sequential block-RAM reads and streams the returned words
// through a 4-entry FIFO to a valid/ready sink.
module mem_stream_reader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   remaining_q;
    logic               inflight_q;
    logic [DATA_W-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W:0]     occupancy;
    logic               room;
    logic               issue;
    logic               load;
    logic               push;
    logic               pop;

    // Reads in flight count against FIFO space so the FIFO can never overflow.
    assign occupancy = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q);
    assign room      = (occupancy < (CNT_W+1)'(DEPTH)) && (remaining_q != '0);

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : '0;
    assign busy      = (state_q != IDLE);
    assign mem_addr  = addr_q;
    assign mem_en    = issue;
    assign push      = inflight_q && !abort;
    assign pop       = out_valid && out_ready && !abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        load    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    load    = 1'b1;
                    state_d = (length == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (room) begin
                    issue = 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Finished once nothing is in flight and the last word leaves (or none existed).
                if (abort) begin
                    state_d = IDLE;
                end else if (!inflight_q &&
                             ((count_q == '0) || ((count_q == CNT_W'(1)) && pop))) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address generator and remaining-word counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (load) begin
                addr_q      <= base_addr;
                remaining_q <= length;
            end else if (abort) begin
                remaining_q <= '0;
            end else if (issue) begin
                addr_q      <= addr_q + ADDR_W'(1);
                remaining_q <= remaining_q - LEN_W'(1);
            end
        end
    end

    // FIFO pointers and occupancy; abort flushes everything including the inflight word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_dout;
        end
    end

endmodule
